// File: rtl/sumador_pkg.sv
// sumador_pkg: shared widths and tagged result entry for the sumador adder pipe
package sumador_pkg;
  localparam int DATA_W = 4;
  localparam int IDX_W = 4;
  localparam int ENTRY_W = IDX_W + DATA_W;
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [DATA_W-1:0] sum;
  } entry_t;
endpackage

// File: rtl/sumador_rb_fifo.sv
// sumador_rb_fifo: show-ahead fifo with count-decoded full/empty and zeroed output when empty
module sumador_rb_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_comb begin
    full = count == (AW+1)'(DEPTH);
    empty = count == '0;
    dout = empty ? '0 : mem[rd_ptr];
  end
endmodule

// File: rtl/sumador_result_buffer.sv
// sumador_result_buffer: buffers tagged adder results for a stalling consumer with acc/drop/seq tracking
module sumador_result_buffer #(
  parameter int DATA_W = sumador_pkg::DATA_W,
  parameter int IDX_W = sumador_pkg::IDX_W,
  parameter int DEPTH = 4,
  parameter int ACC_W = 8,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic [DATA_W-1:0] in_sum,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [IDX_W-1:0]  out_idx,
  output logic [DATA_W-1:0] out_sum,
  output logic              full,
  output logic              empty,
  output logic [ACC_W-1:0]  acc,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              seq_err
);
  import sumador_pkg::*;
  localparam int W = IDX_W + DATA_W;
  logic pop, push, drop, first;
  logic [W-1:0] head;
  logic [IDX_W-1:0] last_idx;
  always_comb begin
    out_valid = !empty;
    pop = out_valid && out_ready;
    push = in_valid && (!full || pop);
    drop = in_valid && full && !pop;
    {out_idx, out_sum} = head;
  end
  sumador_rb_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din({in_idx, in_sum}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      acc <= '0;
      drop_cnt <= '0;
      seq_err <= 1'b0;
      last_idx <= '0;
      first <= 1'b1;
    end else if (push) begin
      acc <= acc + ACC_W'(in_sum);
      seq_err <= seq_err || (!first && in_idx != last_idx + IDX_W'(1));
      last_idx <= in_idx;
      first <= 1'b0;
    end else if (drop && !(&drop_cnt)) begin
      drop_cnt <= drop_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_sumador_result_buffer.sv
// tb_sumador_result_buffer: queue-model scoreboard plus directed literal checks
module tb_sumador_result_buffer;
  logic clk = 0;
  logic reset = 0;
  logic in_valid = 0;
  logic [3:0] in_idx = 0;
  logic [3:0] in_sum = 0;
  logic out_ready = 0;
  logic out_valid, full, empty, seq_err;
  logic [3:0] out_idx, out_sum;
  logic [7:0] acc, drop_cnt;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] q[$];
  int macc = 0;
  int mdrop = 0;
  int mlast = 0;
  bit mseq = 0;
  bit mfirst = 1;
  bit mpop;
  sumador_result_buffer dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_idx(in_idx),
    .in_sum(in_sum),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_idx(out_idx),
    .out_sum(out_sum),
    .full(full),
    .empty(empty),
    .acc(acc),
    .drop_cnt(drop_cnt),
    .seq_err(seq_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      macc = 0;
      mdrop = 0;
      mlast = 0;
      mseq = 0;
      mfirst = 1;
    end else begin
      mpop = q.size() != 0 && out_ready;
      if (in_valid && (q.size() < 4 || mpop)) begin
        if (mpop) void'(q.pop_front());
        q.push_back({in_idx, in_sum});
        macc = (macc + int'(in_sum)) % 256;
        if (!mfirst && int'(in_idx) != (mlast + 1) % 16) mseq = 1;
        mlast = int'(in_idx);
        mfirst = 0;
      end else begin
        if (mpop) void'(q.pop_front());
        if (in_valid && mdrop < 255) mdrop++;
      end
    end
  end
  always @(negedge clk) begin
    check("out_valid", out_valid, q.size() != 0);
    check("out_idx", out_idx, q.size() != 0 ? q[0][7:4] : 4'd0);
    check("out_sum", out_sum, q.size() != 0 ? q[0][3:0] : 4'd0);
    check("full", full, q.size() == 4);
    check("empty", empty, q.size() == 0);
    check("acc", acc, macc);
    check("drop_cnt", drop_cnt, mdrop);
    check("seq_err", seq_err, mseq);
  end
  task automatic drive(input bit v, input int i, input int s, input bit r);
    in_valid = v;
    in_idx = 4'(i);
    in_sum = 4'(s);
    out_ready = r;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_reset();
    in_valid = 0;
    reset = 0;
    @(posedge clk);
    #1;
    reset = 1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", empty, 1);
    check("rst_acc", acc, 0);
    reset = 1;
    drive(1, 2, 5, 1);
    check("lat_valid", out_valid, 1);
    check("lat_idx", out_idx, 2);
    drive(1, 3, 9, 1);
    drive(1, 4, 15, 1);
    repeat (3) drive(0, 0, 0, 1);
    check("pass_acc", acc, 29);
    check("pass_seq", seq_err, 0);
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, i, i + 1, 0);
      if (i == 3) check("fill_full", full, 1);
    end
    check("fill_drop", drop_cnt, 2);
    check("fill_seq0", seq_err, 0);
    check("fill_head", out_idx, 0);
    repeat (5) drive(0, 0, 0, 1);
    check("drain_empty", empty, 1);
    drive(1, 6, 7, 0);
    check("gap_seq", seq_err, 1);
    pulse_reset();
    for (int i = 0; i < 4; i++) drive(1, i, 2, 0);
    drive(1, 4, 3, 1);
    check("fp_full", full, 1);
    check("fp_head", out_idx, 1);
    check("fp_drop", drop_cnt, 0);
    pulse_reset();
    for (int i = 0; i < 20; i++) drive(1, (10 + i) % 16, 15, 1);
    repeat (2) drive(0, 0, 0, 1);
    check("wrap_acc", acc, 44);
    check("wrap_seq", seq_err, 0);
    pulse_reset();
    for (int i = 0; i < 304; i++) drive(1, i % 16, 1, 0);
    check("sat_drop", drop_cnt, 255);
    pulse_reset();
    for (int i = 0; i < 3; i++) drive(1, i, 4, 0);
    check("mid_valid0", out_valid, 1);
    #2;
    reset = 0;
    #1;
    check("mid_valid", out_valid, 0);
    check("mid_empty", empty, 1);
    check("mid_acc", acc, 0);
    check("mid_drop", drop_cnt, 0);
    check("mid_seq", seq_err, 0);
    @(posedge clk);
    #1;
    reset = 1;
    repeat (2) drive(0, 0, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
